// File: rtl/accel_dma_pkg.sv
// accel_dma_pkg: shared types and constants for the accelerator readback DMA and the custom-instruction unit.
package accel_dma_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} dma_state_t;
    localparam logic [31:0] ACCEL_BASE_DEFAULT = 32'h0200_0000;
    localparam int ACCEL_WIN_BITS = 8;
    localparam int DMA_LEN_W = 16;
    localparam logic [1:0] CMD_DMA_READBACK = 2'b11;
endpackage

// File: rtl/accel_result_dma.sv
// accel_result_dma: copies result words from the accelerator MMIO window into RAM, one read then one write per word.
// Optional ACCEL_DMA_TIMEOUT_EN bounds how long a read may wait for accel_mem_ready.
import accel_dma_pkg::*;

module accel_result_dma #(
    parameter int RAM_AW = 12,
    parameter logic [31:0] ACCEL_BASE = ACCEL_BASE_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_src_off,
    input  logic [31:0]          cmd_dst_addr,
    input  logic [15:0]          cmd_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          words_done,
    output logic                 accel_mem_valid,
    output logic                 accel_mem_write,
    output logic [31:0]          accel_mem_addr,
    input  logic [31:0]          accel_mem_rdata,
    input  logic                 accel_mem_ready,
    output logic                 ram_req,
    input  logic                 ram_gnt,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [31:0]          ram_wdata
);
    dma_state_t r_state, w_next;
    logic [ACCEL_WIN_BITS-1:0] r_src_off, w_off;
    logic [RAM_AW-1:0] r_dst_idx;
    logic [DMA_LEN_W-1:0] r_len, r_pos, r_words_done;
    logic [31:0] r_data;
    logic r_err, w_last, w_tmo_hit, w_unused;

    assign w_unused = ^{cmd_dst_addr[31:RAM_AW+2], cmd_dst_addr[1:0]};
    // Source offset wraps inside the 256-byte window.
    assign w_off = r_src_off + {r_pos[ACCEL_WIN_BITS-3:0], 2'b00};
    assign w_last = (r_pos + 16'd1) == r_len;

`ifdef ACCEL_DMA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    assign w_tmo_hit = r_state == RD && !accel_mem_ready && r_tmo == TMO_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tmo <= '0;
        else r_tmo <= (r_state == RD && !accel_mem_ready && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (cmd_valid) w_next = (cmd_len == '0) ? DONE : RD;
            RD:   w_next = (abort || w_tmo_hit) ? DONE : accel_mem_ready ? WR : RD;
            WR:   w_next = (abort || (ram_gnt && w_last)) ? DONE : ram_gnt ? RD : WR;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_src_off <= '0;
            r_dst_idx <= '0;
            r_len <= '0;
            r_pos <= '0;
            r_words_done <= '0;
            r_data <= '0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cmd_valid) begin
                r_src_off <= cmd_src_off;
                r_dst_idx <= cmd_dst_addr[RAM_AW+1:2];
                r_len <= cmd_len;
                r_pos <= '0;
                r_words_done <= '0;
                r_err <= 1'b0;
            end
            if (r_state == RD && accel_mem_ready && !abort) r_data <= accel_mem_rdata;
            // A granted write in the abort cycle still commits and is counted.
            if (r_state == WR && ram_gnt) begin
                r_words_done <= r_words_done + 1'b1;
                if (!abort && !w_last) r_pos <= r_pos + 1'b1;
            end
            if ((r_state == RD || r_state == WR) && (abort || w_tmo_hit)) r_err <= 1'b1;
        end
    end

    assign cmd_ready = r_state == IDLE;
    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
    assign err = r_err;
    assign words_done = r_words_done;
    assign accel_mem_valid = r_state == RD;
    assign accel_mem_write = 1'b0;
    assign accel_mem_addr = accel_mem_valid ? (ACCEL_BASE | {{(32-ACCEL_WIN_BITS){1'b0}}, w_off}) : '0;
    assign ram_req = r_state == WR;
    assign ram_addr = ram_req ? r_dst_idx + r_pos[RAM_AW-1:0] : '0;
    assign ram_wdata = ram_req ? r_data : '0;
endmodule

// File: doc/accel_result_dma.md
Name: accel_result_dma

Overview:
Read-direction DMA engine for the matrix-accelerator subsystem. It copies a block of result words from accelerator MMIO space (ACCEL_BASE window) back into on-chip RAM, freeing the CPU from word-by-word loads and stores. It is the counterpart of the existing RAM-to-accelerator DMA path. It is started by a one-cycle command from the custom-instruction unit, acts as initiator on the accelerator MMIO bus and as a write requester on a RAM write port arbitrated against the CPU.

Parameters:
RAM_AW, 12, RAM word-index width (4096 words, 16KB).
ACCEL_BASE, 32'h0200_0000, base byte address of the accelerator MMIO window.
TIMEOUT_CYCLES, 1024, accelerator no-ready limit (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  start request; sampled only when cmd_ready=1
cmd_ready  out  1  high only in IDLE
cmd_src_off  in  8  accelerator byte offset of first word
cmd_dst_addr  in  32  RAM byte address of first word; bits [1:0] ignored
cmd_len  in  16  word count
abort  in  1  terminate active transfer
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky abort/timeout flag
words_done  out  16  count of RAM words written in the current/last transfer
accel_mem_valid  out  1  MMIO read request
accel_mem_write  out  1  tied to 0 (read-only initiator)
accel_mem_addr  out  32  MMIO byte address
accel_mem_rdata  in  32  MMIO read data, valid with ready
accel_mem_ready  in  1  MMIO completion; may be high in the same cycle as valid
ram_req  out  1  RAM write request
ram_gnt  in  1  grant; write commits on the clock edge where ram_req&&ram_gnt
ram_addr  out  RAM_AW  RAM word index
ram_wdata  out  32  write data (full word, all byte strobes)

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All outputs are 0 in reset except cmd_ready=1. State is IDLE; pos, words_done, err and the data register are all 0.
- States are IDLE, RD, WR, DONE.
- IDLE: on cmd_valid, latch src_off, dst word index (cmd_dst_addr[RAM_AW+1:2]) and len. Clear pos, words_done and err.
  - If len==0, go to DONE.
  - Otherwise go to RD.
- RD: accel_mem_valid=1 and accel_mem_addr = ACCEL_BASE | {24'b0, (src_off + pos*4)[7:0]}. The offset wraps modulo 256.
  - On accel_mem_ready, capture rdata into the data register and go to WR.
  - Otherwise stay in RD and hold the address stable.
- WR: ram_req=1, ram_addr = (dst_idx + pos) mod 2^RAM_AW, ram_wdata = data register.
  - On ram_gnt, words_done increments.
  - If pos+1==len, go to DONE; else pos increments and go to RD.
  - Without gnt, stay in WR and hold all outputs.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Throughput: 2 cycles per word when ready and gnt are immediate. For a command accepted at edge E0, done is high during cycle 2*len+1 after E0.
- Abort in RD or WR: go to DONE next edge and set err.
  - Read data returned in the abort cycle is discarded.
  - In WR, if ram_gnt is high in the abort cycle, the write commits and is counted before going to DONE.
  - Abort in IDLE or DONE is ignored.
- cmd_valid while not IDLE is ignored; there is no queueing.
- err stays set until the next accepted command.
- Asynchronous reset mid-transfer returns to IDLE immediately. No done pulse is produced, and a partially written RAM block is left as is.
- len is 16 bits, so 65535 is the maximum transfer. RAM index wrap past 2^RAM_AW is legal and silent.

Optional Feature:
ACCEL_DMA_TIMEOUT_EN
- Defined: a counter runs while in RD without accel_mem_ready. At TIMEOUT_CYCLES it forces DONE with err=1, and accel_mem_valid drops on the following cycle. The counter clears on every ready and on entry to RD.
- Undefined: no counter; RD waits indefinitely and only abort or rst exit it.

Decomposition:
- Package accel_dma_pkg holds:
  - the dma_state_t enum (IDLE, RD, WR, DONE)
  - ACCEL_BASE_DEFAULT, ACCEL_WIN_BITS=8 and DMA_LEN_W=16
  - the cmd type code for DMA-readback (2'b11), shared with the custom-instruction unit.
- No sub-module is needed. The single FSM plus datapath is roughly 180 lines, and the timeout counter stays inline under `ifdef.

Test Plan:
- Zero-wait copy: accel offsets 0x20..0x2C preloaded with 0x11,0x22,0x33,0x44; cmd src_off=0x20, dst=0x100, len=4 -> RAM words 64..67 = 0x11..0x44, done in cycle 9 after accept, words_done=4, err=0.
- Backpressure: ready delayed 3 cycles per read and gnt withheld 2 cycles per write -> addresses and data stay stable while waiting, final RAM contents correct, exactly 4 writes.
- len=0 -> done in cycle 1, no accel_mem_valid, no ram_req, words_done=0.
- Wrap: src_off=0xFC, len=2 -> accel addrs 0x020000FC then 0x02000000. dst=0x3FFC -> RAM indices 4095 then 0.
- Abort in WR with gnt=1 on word 2 of 8 -> words_done=2, done pulse, err=1. The next command clears err, and a second cmd_valid during busy is ignored.
- ACCEL_DMA_TIMEOUT_EN with TIMEOUT_CYCLES=16 and ready held low -> done and err=1 at the 16th wait cycle. A mid-transfer rst pulse returns busy=0 and cmd_ready=1 with no done.
